// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: bundle between the LEGv8 datapath and the pipeline controller.
//   Hazard inputs  : id_rn, id_rm, ex_memread, ex_rd, mem_pcsrc, mem_req, dmem_ready
//   Stage controls : pc_en, ifid_en/flush, idex_en/flush, exmem_en/flush, memwb_flush
//   Status         : mem_timeout, stall_count[CW], flush_count[CW]
//   master = datapath side, slave = controller side.
interface pipe_ctrl_if #(
  parameter int unsigned CW = 32
);
  logic          id_rn_unused_guard;
  logic [4:0]    id_rn;
  logic [4:0]    id_rm;
  logic          ex_memread;
  logic [4:0]    ex_rd;
  logic          mem_pcsrc;
  logic          mem_req;
  logic          dmem_ready;

  logic          pc_en;
  logic          ifid_en;
  logic          ifid_flush;
  logic          idex_en;
  logic          idex_flush;
  logic          exmem_en;
  logic          exmem_flush;
  logic          memwb_flush;
  logic          mem_timeout;
  logic [CW-1:0] stall_count;
  logic [CW-1:0] flush_count;

  modport master (
    output id_rn, id_rm, ex_memread, ex_rd, mem_pcsrc, mem_req, dmem_ready,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           exmem_flush, memwb_flush, mem_timeout, stall_count, flush_count
  );

  modport slave (
    input  id_rn, id_rm, ex_memread, ex_rd, mem_pcsrc, mem_req, dmem_ready,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           exmem_flush, memwb_flush, mem_timeout, stall_count, flush_count
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: sequencing controller for the 5-stage LEGv8 pipeline.
// Resolves load-use stalls, MEM-stage branch flushes and data-memory waits
// (with a timeout watchdog), and keeps saturating stall/flush counters.
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous, active-high
//   bus   - pipe_ctrl_if.slave: hazard inputs in, stage enables/flushes,
//           mem_timeout and performance counters out
// Enables/flushes are combinational (zero latency); counters and
// mem_timeout are registered.
module pipe_ctrl #(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CW       = 32
) (
  input  logic      clk,
  input  logic      reset,
  pipe_ctrl_if.slave bus
);

  localparam int unsigned WW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_ERROR = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [CW-1:0] stall_cnt_q, stall_cnt_d;
  logic [CW-1:0] flush_cnt_q, flush_cnt_d;
  logic          timeout_q, timeout_d;

  logic mstall, lu, freeze, take_branch, take_lu;
  logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic exmem_en, exmem_flush, memwb_flush;

  // Hazard detection; X31 (XZR) never produces a load-use hazard.
  always_comb begin
    mstall      = bus.mem_req & ~bus.dmem_ready;
    lu          = bus.ex_memread & (bus.ex_rd != 5'd31) &
                  ((bus.ex_rd == bus.id_rn) | (bus.ex_rd == bus.id_rm));
    freeze      = (state_q == S_ERROR) | mstall;
    take_branch = ~freeze & bus.mem_pcsrc;
    take_lu     = ~freeze & ~bus.mem_pcsrc & lu;
  end

  // Stage enables/flushes: ERROR > memory freeze > branch > load-use.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_en     = 1'b1;
    idex_flush  = 1'b0;
    exmem_en    = 1'b1;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    if (reset) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b1;
      idex_en     = 1'b0;
      idex_flush  = 1'b1;
      exmem_en    = 1'b0;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
    end else if (freeze) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
    end else if (take_branch) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (take_lu) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_flush  = 1'b1;
    end
  end

  // Next state, watchdog and saturating counters.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    timeout_d   = timeout_q;

    case (state_q)
      S_RUN: begin
        if (mstall) begin
          state_d    = S_WAIT;
          wait_cnt_d = WW'(1);
        end
      end
      S_WAIT: begin
        if (!mstall) begin
          state_d    = S_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WW'(MAX_WAIT - 1)) begin
          state_d = S_ERROR;
        end else begin
          wait_cnt_d = wait_cnt_q + WW'(1);
        end
      end
      S_ERROR: state_d = S_ERROR;
      default: begin
        state_d    = S_RUN;
        wait_cnt_d = '0;
      end
    endcase

    // Sticky from the first cycle spent in ERROR.
    if (state_d == S_ERROR) timeout_d = 1'b1;

    // ERROR cycles are not counted as stalls.
    if (!pc_en && (state_q != S_ERROR) && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CW'(1);
    if (take_branch && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + CW'(1);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.pc_en       = pc_en;
  assign bus.ifid_en     = ifid_en;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_en     = idex_en;
  assign bus.idex_flush  = idex_flush;
  assign bus.exmem_en    = exmem_en;
  assign bus.exmem_flush = exmem_flush;
  assign bus.memwb_flush = memwb_flush;
  assign bus.mem_timeout = timeout_q;
  assign bus.stall_count = stall_cnt_q;
  assign bus.flush_count = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl (MAX_WAIT=4, CW=4).
module tb_pipe_ctrl;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  pipe_ctrl_if #(.CW(4)) bus ();

  pipe_ctrl #(.MAX_WAIT(4), .CW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_flush}
  logic [7:0] ctl;
  assign ctl = {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en,
                bus.idex_flush, bus.exmem_en, bus.exmem_flush, bus.memwb_flush};

  localparam logic [7:0] C_NORM = 8'b1101_0100;
  localparam logic [7:0] C_RST  = 8'b0010_1011;
  localparam logic [7:0] C_FRZ  = 8'b0000_0001;
  localparam logic [7:0] C_BR   = 8'b1111_1110;
  localparam logic [7:0] C_LU   = 8'b0001_1100;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] rn, input logic [4:0] rm, input logic memrd,
                       input logic [4:0] rd, input logic pcsrc, input logic req,
                       input logic rdy);
    bus.id_rn      = rn;
    bus.id_rm      = rm;
    bus.ex_memread = memrd;
    bus.ex_rd      = rd;
    bus.mem_pcsrc  = pcsrc;
    bus.mem_req    = req;
    bus.dmem_ready = rdy;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("rst_ctl", 32'(ctl), 32'(C_RST));
    tick();
    tick();
    chk("rst_stall", 32'(bus.stall_count), 32'd0);
    chk("rst_flush", 32'(bus.flush_count), 32'd0);
    chk("rst_timeout", 32'(bus.mem_timeout), 32'd0);
    reset = 1'b0;
    #1;
    chk("idle_ctl", 32'(ctl), 32'(C_NORM));

    // Load-use via Rn, then X31, then via Rm, then non-load match.
    drive(5'd3, 5'd0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
    chk("lu_rn_ctl", 32'(ctl), 32'(C_LU));
    tick();
    chk("lu_rn_stall", 32'(bus.stall_count), 32'd1);
    drive(5'd31, 5'd0, 1'b1, 5'd31, 1'b0, 1'b0, 1'b0);
    chk("lu_x31_ctl", 32'(ctl), 32'(C_NORM));
    tick();
    chk("lu_x31_stall", 32'(bus.stall_count), 32'd1);
    drive(5'd0, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    chk("lu_rm_ctl", 32'(ctl), 32'(C_LU));
    tick();
    chk("lu_rm_stall", 32'(bus.stall_count), 32'd2);
    drive(5'd5, 5'd5, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0);
    chk("nolu_ctl", 32'(ctl), 32'(C_NORM));

    // Branch wins over load-use.
    drive(5'd3, 5'd0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    chk("br_ctl", 32'(ctl), 32'(C_BR));
    tick();
    chk("br_flush", 32'(bus.flush_count), 32'd1);
    chk("br_stall", 32'(bus.stall_count), 32'd2);

    // Memory wait: three stall cycles (MAX_WAIT-1) then ready.
    do_reset();
    chk("rst2_stall", 32'(bus.stall_count), 32'd0);
    chk("rst2_flush", 32'(bus.flush_count), 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      chk($sformatf("mw_frz%0d", i), 32'(ctl), 32'(C_FRZ));
      tick();
    end
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    chk("mw_done_ctl", 32'(ctl), 32'(C_NORM));
    tick();
    chk("mw_stall", 32'(bus.stall_count), 32'd3);
    chk("mw_timeout", 32'(bus.mem_timeout), 32'd0);
    // A fresh single-cycle wait must start from a cleared watchdog.
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("mw2_ctl", 32'(ctl), 32'(C_NORM));
    tick();
    chk("mw2_stall", 32'(bus.stall_count), 32'd4);
    chk("mw2_timeout", 32'(bus.mem_timeout), 32'd0);

    // Timeout: four stall cycles, then ERROR.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      chk($sformatf("to_frz%0d", i), 32'(ctl), 32'(C_FRZ));
      chk($sformatf("to_flag%0d", i), 32'(bus.mem_timeout), 32'd0);
      tick();
    end
    chk("to_set", 32'(bus.mem_timeout), 32'd1);
    chk("to_stall", 32'(bus.stall_count), 32'd4);
    drive(5'd3, 5'd0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    chk("err_ctl", 32'(ctl), 32'(C_FRZ));
    tick();
    chk("err_stall", 32'(bus.stall_count), 32'd4);
    chk("err_flush", 32'(bus.flush_count), 32'd0);
    chk("err_sticky", 32'(bus.mem_timeout), 32'd1);
    reset = 1'b1;
    #1;
    chk("err_rst_ctl", 32'(ctl), 32'(C_RST));
    tick();
    reset = 1'b0;
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("err_rst_timeout", 32'(bus.mem_timeout), 32'd0);
    chk("err_rst_stall", 32'(bus.stall_count), 32'd0);
    chk("err_rst_ctl2", 32'(ctl), 32'(C_NORM));

    // Branch held during a freeze is applied once memory completes.
    for (int i = 0; i < 2; i++) begin
      drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
      chk($sformatf("fb_frz%0d", i), 32'(ctl), 32'(C_FRZ));
      tick();
    end
    chk("fb_flush0", 32'(bus.flush_count), 32'd0);
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
    chk("fb_br_ctl", 32'(ctl), 32'(C_BR));
    tick();
    chk("fb_flush1", 32'(bus.flush_count), 32'd1);
    chk("fb_stall", 32'(bus.stall_count), 32'd2);

    // Saturation of the 4-bit stall counter.
    do_reset();
    drive(5'd3, 5'd0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    chk("sat_stall", 32'(bus.stall_count), 32'd15);
    chk("sat_ctl", 32'(ctl), 32'(C_LU));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
